// File: rtl/memory_arbiter_if.sv
// memory_arbiter_if: bundles the fetch port, the load/store port and the
// memory-side signals of the shared instruction/data memory arbiter.
//   I port : iReq/iAddr in, iGnt/iRdata/iValid/iErr out (arbiter view)
//   D port : dReq/dWe/dAddr/dWdata in, dGnt/dRdata/dValid/dErr out
//   Memory : memAddr/memWriteData/memWriteEnable out, memRead in
// slave  = arbiter side, master = requesters plus memory side.
interface memory_arbiter_if;
  logic        iReq;
  logic [31:0] iAddr;
  logic        iGnt;
  logic [31:0] iRdata;
  logic        iValid;
  logic        iErr;
  logic        dReq;
  logic        dWe;
  logic [31:0] dAddr;
  logic [31:0] dWdata;
  logic        dGnt;
  logic [31:0] dRdata;
  logic        dValid;
  logic        dErr;
  logic [31:0] memAddr;
  logic [31:0] memWriteData;
  logic        memWriteEnable;
  logic [31:0] memRead;

  modport slave (
    input  iReq, iAddr, dReq, dWe, dAddr, dWdata, memRead,
    output iGnt, iRdata, iValid, iErr, dGnt, dRdata, dValid, dErr,
           memAddr, memWriteData, memWriteEnable
  );

  modport master (
    output iReq, iAddr, dReq, dWe, dAddr, dWdata, memRead,
    input  iGnt, iRdata, iValid, iErr, dGnt, dRdata, dValid, dErr,
           memAddr, memWriteData, memWriteEnable
  );
endinterface

// File: rtl/memory_arbiter.sv
// memory_arbiter: grants one access per cycle to a single combined
// instruction/data memory, data port first, with a streak counter that
// forces a fetch grant after MAX_D_STREAK consecutive data grants while
// fetch waits. Bad addresses (misaligned or beyond DEPTH_WORDS) are granted
// and consumed but never reach memory; they answer with Err=1, Rdata=0.
// Ports:
//   clk   : system clock, all state on posedge
//   reset : synchronous, active-high
//   bus   : memory_arbiter_if.slave (requester ports + memory ports)
// Grants and memory drive are combinational; responses are registered and
// appear one cycle after the grant.
module memory_arbiter #(
  parameter int DEPTH_WORDS  = 64,
  parameter int MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset,
  memory_arbiter_if.slave   bus
);

  localparam logic [29:0] DEPTH_LIM  = 30'(DEPTH_WORDS);
  localparam logic [3:0]  STREAK_MAX = 4'(MAX_D_STREAK);

  // Misaligned or past the last word index.
  function automatic logic addr_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[31:2] >= DEPTH_LIM);
  endfunction

  logic [3:0]  streak_r;
  logic        i_gnt_s;
  logic        d_gnt_s;
  logic        bad_s;
  logic [31:0] mem_addr_s;
  logic [31:0] mem_wdata_s;
  logic        mem_we_s;
  logic [31:0] i_rdata_r;
  logic        i_valid_r;
  logic        i_err_r;
  logic [31:0] d_rdata_r;
  logic        d_valid_r;
  logic        d_err_r;

  // Arbitration, address check and memory drive.
  always_comb begin
    i_gnt_s     = 1'b0;
    d_gnt_s     = 1'b0;
    bad_s       = 1'b0;
    mem_addr_s  = 32'd0;
    mem_wdata_s = 32'd0;
    mem_we_s    = 1'b0;
    if (!reset) begin
      case ({bus.dReq, bus.iReq})
        2'b10:   d_gnt_s = 1'b1;
        2'b01:   i_gnt_s = 1'b1;
        2'b11: begin
          // Fetch wins only once data has used up its streak allowance.
          if (streak_r == STREAK_MAX) begin
            i_gnt_s = 1'b1;
          end else begin
            d_gnt_s = 1'b1;
          end
        end
        default: begin
          i_gnt_s = 1'b0;
          d_gnt_s = 1'b0;
        end
      endcase

      if (d_gnt_s) begin
        mem_addr_s  = bus.dAddr;
        bad_s       = addr_bad(bus.dAddr);
        mem_wdata_s = bus.dWdata;
        mem_we_s    = bus.dWe & ~bad_s;
      end else if (i_gnt_s) begin
        mem_addr_s  = bus.iAddr;
        bad_s       = addr_bad(bus.iAddr);
      end else begin
        mem_addr_s  = 32'd0;
      end
    end else begin
      mem_we_s = 1'b0;
    end
  end

  // Streak counter: counts data grants that made a waiting fetch wait longer.
  always_ff @(posedge clk) begin
    if (reset) begin
      streak_r <= 4'd0;
    end else if (i_gnt_s || !bus.iReq) begin
      streak_r <= 4'd0;
    end else if (d_gnt_s && (streak_r != STREAK_MAX)) begin
      streak_r <= streak_r + 4'd1;
    end else begin
      streak_r <= streak_r;
    end
  end

  // Responses: capture read data of the granted port at the end of the grant cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      i_rdata_r <= 32'd0;
      i_valid_r <= 1'b0;
      i_err_r   <= 1'b0;
      d_rdata_r <= 32'd0;
      d_valid_r <= 1'b0;
      d_err_r   <= 1'b0;
    end else begin
      i_valid_r <= i_gnt_s;
      i_err_r   <= i_gnt_s & bad_s;
      d_valid_r <= d_gnt_s;
      d_err_r   <= d_gnt_s & bad_s;
      if (i_gnt_s) begin
        i_rdata_r <= bad_s ? 32'd0 : bus.memRead;
      end
      if (d_gnt_s) begin
        // Stores answer with zero data; the write lands on this same edge.
        d_rdata_r <= (bad_s || bus.dWe) ? 32'd0 : bus.memRead;
      end
    end
  end

  assign bus.iGnt           = i_gnt_s;
  assign bus.dGnt           = d_gnt_s;
  assign bus.memAddr        = mem_addr_s;
  assign bus.memWriteData   = mem_wdata_s;
  assign bus.memWriteEnable = mem_we_s;
  assign bus.iRdata         = i_rdata_r;
  assign bus.iValid         = i_valid_r;
  assign bus.iErr           = i_err_r;
  assign bus.dRdata         = d_rdata_r;
  assign bus.dValid         = d_valid_r;
  assign bus.dErr           = d_err_r;

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed bench with a behavioural memory, a reference
// grant/streak model and a response scoreboard queue.
module tb_memory_arbiter;

  localparam int MAXS = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic mem_load = 1'b1;

  always #5 clk = ~clk;

  memory_arbiter_if bus();

  memory_arbiter #(.DEPTH_WORDS(64), .MAX_D_STREAK(MAXS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Behavioural memory: combinational read, synchronous write.
  logic [31:0] mem [0:63];

  function automatic logic [31:0] init_word(input int k);
    return (k == 32) ? 32'd12 : (32'hA500_0000 | 32'(k));
  endfunction

  assign bus.memRead = mem[bus.memAddr[7:2]];

  always @(posedge clk) begin
    if (mem_load) begin
      for (int k = 0; k < 64; k++) mem[k] <= init_word(k);
    end else if (bus.memWriteEnable) begin
      mem[bus.memAddr[7:2]] <= bus.memWriteData;
    end
  end

  // Reference state.
  logic [31:0] sh [0:63];
  logic [3:0]  m_streak;
  logic [9:0]  hist;

  typedef struct {
    bit          port;   // 0 = I, 1 = D
    logic [31:0] rdata;
    logic        err;
  } resp_t;
  resp_t exp_q[$];

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic bad_addr(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[31:2] >= 30'd64);
  endfunction

  task automatic drive(input logic ir, input logic [31:0] ia, input logic dr,
                       input logic dwe, input logic [31:0] da, input logic [31:0] dwd);
    bus.iReq   = ir;
    bus.iAddr  = ia;
    bus.dReq   = dr;
    bus.dWe    = dwe;
    bus.dAddr  = da;
    bus.dWdata = dwd;
  endtask

  task automatic check_resp();
    resp_t r;
    if (exp_q.size() > 0) begin
      r = exp_q.pop_front();
      if (r.port == 1'b0) begin
        chk("iValid", 32'(bus.iValid), 32'd1);
        chk("dValid_idle", 32'(bus.dValid), 32'd0);
        chk("iRdata", bus.iRdata, r.rdata);
        chk("iErr", 32'(bus.iErr), 32'(r.err));
      end else begin
        chk("dValid", 32'(bus.dValid), 32'd1);
        chk("iValid_idle", 32'(bus.iValid), 32'd0);
        chk("dRdata", bus.dRdata, r.rdata);
        chk("dErr", 32'(bus.dErr), 32'(r.err));
      end
    end else begin
      chk("iValid_none", 32'(bus.iValid), 32'd0);
      chk("dValid_none", 32'(bus.dValid), 32'd0);
    end
  endtask

  // One clock: check combinational grant/memory drive mid-cycle, push the
  // expected response, step the edge, then compare the response.
  task automatic run_cycle();
    logic        eg_i, eg_d, bad;
    logic [31:0] ea, ewd;
    logic        ewe;
    resp_t       r;
    @(negedge clk);
    eg_i = 1'b0; eg_d = 1'b0;
    if (!reset) begin
      if (bus.dReq && bus.iReq) begin
        if (m_streak == 4'(MAXS)) eg_i = 1'b1; else eg_d = 1'b1;
      end else begin
        eg_d = bus.dReq;
        eg_i = bus.iReq;
      end
    end
    ea  = eg_d ? bus.dAddr : (eg_i ? bus.iAddr : 32'd0);
    bad = (eg_d || eg_i) && bad_addr(ea);
    ewd = eg_d ? bus.dWdata : 32'd0;
    ewe = eg_d && bus.dWe && !bad;
    chk("iGnt", 32'(bus.iGnt), 32'(eg_i));
    chk("dGnt", 32'(bus.dGnt), 32'(eg_d));
    chk("memAddr", bus.memAddr, ea);
    chk("memWriteData", bus.memWriteData, ewd);
    chk("memWriteEnable", 32'(bus.memWriteEnable), 32'(ewe));
    hist = {hist[8:0], bus.dGnt};
    if (eg_i) begin
      r.port = 1'b0; r.err = bad; r.rdata = bad ? 32'd0 : sh[ea[7:2]];
      exp_q.push_back(r);
    end else if (eg_d) begin
      r.port = 1'b1; r.err = bad;
      r.rdata = (bad || bus.dWe) ? 32'd0 : sh[ea[7:2]];
      exp_q.push_back(r);
    end
    if (ewe) sh[ea[7:2]] = ewd;
    if (reset || eg_i || !bus.iReq) m_streak = 4'd0;
    else if (eg_d && m_streak != 4'(MAXS)) m_streak = m_streak + 4'd1;
    @(posedge clk);
    #1;
    check_resp();
  endtask

  initial begin
    for (int k = 0; k < 64; k++) sh[k] = init_word(k);
    m_streak = 4'd0;
    hist = 10'd0;
    drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);

    // Reset: memory preload, then outputs at reset values.
    @(posedge clk); #1;
    run_cycle();
    mem_load = 1'b0;
    run_cycle();
    chk("iRdata_rst", bus.iRdata, 32'd0);
    chk("dRdata_rst", bus.dRdata, 32'd0);
    chk("iErr_rst", 32'(bus.iErr), 32'd0);
    chk("dErr_rst", 32'(bus.dErr), 32'd0);
    reset = 1'b0;

    // Fetch of word 32.
    drive(1'b1, 32'h80, 1'b0, 1'b0, 32'd0, 32'd0);
    run_cycle();
    chk("iRdata_word32", bus.iRdata, 32'd12);
    drive(1'b0, 32'h80, 1'b0, 1'b0, 32'd0, 32'd0);
    run_cycle();

    // Store 15 to 0x90, then load it back in the next cycle.
    drive(1'b0, 32'd0, 1'b1, 1'b1, 32'h90, 32'd15);
    run_cycle();
    drive(1'b0, 32'd0, 1'b1, 1'b0, 32'h90, 32'hDEAD_BEEF);
    run_cycle();
    chk("load_after_store", bus.dRdata, 32'd15);
    drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    run_cycle();

    // Both requesting continuously: D,D,D,D,I,D,D,D,D,I.
    drive(1'b1, 32'h80, 1'b1, 1'b0, 32'h84, 32'd0);
    for (int n = 0; n < 10; n++) run_cycle();
    chk("grant_pattern", 32'(hist), 32'(10'b1111011110));
    drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    run_cycle();

    // Bad stores: misaligned, out of range.
    drive(1'b0, 32'd0, 1'b1, 1'b1, 32'h92, 32'd77);
    run_cycle();
    chk("misaligned_err", 32'(bus.dErr), 32'd1);
    drive(1'b0, 32'd0, 1'b1, 1'b1, 32'h100, 32'd88);
    run_cycle();
    chk("range_err", 32'(bus.dErr), 32'd1);
    drive(1'b0, 32'd0, 1'b1, 1'b0, 32'h90, 32'd0);
    run_cycle();
    chk("after_bad_load", bus.dRdata, 32'd15);
    drive(1'b1, 32'h100, 1'b0, 1'b0, 32'd0, 32'd0);
    run_cycle();
    chk("fetch_range_rdata", bus.iRdata, 32'd0);

    // Reset during a store grant cycle.
    drive(1'b0, 32'd0, 1'b1, 1'b1, 32'h90, 32'd99);
    reset = 1'b1;
    run_cycle();
    chk("rst_dRdata", bus.dRdata, 32'd0);
    chk("rst_iRdata", bus.iRdata, 32'd0);
    chk("rst_dErr", 32'(bus.dErr), 32'd0);
    reset = 1'b0;
    drive(1'b0, 32'd0, 1'b1, 1'b0, 32'h90, 32'd0);
    run_cycle();
    chk("no_write_on_reset", bus.dRdata, 32'd15);

    // D streak of 3, idle, then simultaneous requests grant D.
    drive(1'b1, 32'h80, 1'b1, 1'b0, 32'h84, 32'd0);
    for (int n = 0; n < 3; n++) run_cycle();
    drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    for (int n = 0; n < 3; n++) run_cycle();
    drive(1'b1, 32'h80, 1'b1, 1'b0, 32'h84, 32'd0);
    #3;
    chk("dGnt_after_idle", 32'(bus.dGnt), 32'd1);
    for (int n = 0; n < 5; n++) run_cycle();
    chk("streak_after_idle", 32'(hist[4:0]), 32'(5'b11110));
    drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    run_cycle();
    run_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
